fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues sequential requests to a 1-cycle-latency instruction memory.
- Buffers returned instructions with their PCs in a small FIFO, so IF/ID stalls do not drop fetches.
- Accepts redirects from branch resolution; a redirect flushes the FIFO and kills the in-flight fetch.

---
 rtl/fetch_queue.sv | 150 +++++++++++++++
 tb/tb_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential requests to a
// 1-cycle instruction memory and buffers {instr, pc} pairs. Optional: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [63:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [31:0]              deq_instr,
  output logic [63:0]              deq_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, KILL} state_e;

  state_e         state_q, state_d;
  logic [63:0]    fetch_pc_q;
  logic           inflight_q;
  logic [63:0]    inflight_pc_q;
  logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PW:0]    count_q;

  logic [31:0]    instr_mem [DEPTH];
  logic [63:0]    pc_mem    [DEPTH];

  logic [PW:0]    pending;
  logic           room;
  logic           bypass;
  logic           enq;
  logic           pop;

  // In-flight request reserves a slot so its response can never overflow the FIFO.
  assign pending = count_q + {{PW{1'b0}}, inflight_q};
  assign room    = (pending < FULL_CNT);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= BOOT;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = KILL;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        KILL:    state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    imem_req = 1'b0;
    if (state_q == RUN && !redirect_valid && room) imem_req = 1'b1;
  end

  assign imem_addr = fetch_pc_q;

  // ---------------- datapath control ----------------
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && inflight_q && deq_ready && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // A redirect drops the response arriving this cycle; it belongs to the old path.
  assign enq = inflight_q && !redirect_valid && !bypass;
  assign pop = (count_q != '0) && deq_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC & ~64'h3;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc & ~64'h3;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + 64'd4;
      end
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({enq, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q gates every read,
  // so stale contents are never observed and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // ---------------- dequeue side ----------------
  always_comb begin
    deq_valid = 1'b0;
    deq_instr = NOP_INSTR;
    deq_pc    = '0;
    if (count_q != '0) begin
      deq_valid = 1'b1;
      deq_instr = instr_mem[rd_ptr_q];
      deq_pc    = pc_mem[rd_ptr_q];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      deq_valid = 1'b1;
      deq_instr = imem_rdata;
      deq_pc    = inflight_pc_q;
    end
`endif
  end

  assign occupancy = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, scoreboard-based bench for fetch_queue: expected PC streams are queued
// at each (re)start point and popped on every deq handshake.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'hD503201F;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [63:0] deq_pc;
  logic [$clog2(DEPTH):0] occupancy;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned n_0x20      = 0;
  logic [63:0] sb [$];

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_instr      (deq_instr),
    .deq_pc         (deq_pc),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_5A5A;
  endfunction

  // 1-cycle-latency instruction memory returning address-derived words.
  always @(posedge clk) if (imem_req) imem_rdata <= instr_of(imem_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_restart(input logic [63:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 64'(4 * i));
  endtask

  // One clock: check outputs at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (imem_req === 1'b1) check("addr_align", {62'd0, imem_addr[1:0]}, 64'd0);
    if (deq_valid === 1'b1 && deq_ready === 1'b1) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_empty: observed deq_pc %0h, expected no handshake", deq_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("deq_pc", deq_pc, e);
        check("deq_instr", {32'd0, deq_instr}, {32'd0, instr_of(e)});
      end
      if (deq_pc === 64'h20) n_0x20++;
    end else if (deq_valid === 1'b0) begin
      check("empty_instr", {32'd0, deq_instr}, {32'd0, NOP});
      check("empty_pc", deq_pc, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_req"},   {63'd0, imem_req}, 64'd0);
    check({phase, "_valid"}, {63'd0, deq_valid}, 64'd0);
    check({phase, "_instr"}, {32'd0, deq_instr}, {32'd0, NOP});
    check({phase, "_pc"},    deq_pc, 64'd0);
    check({phase, "_occ"},   64'(occupancy), 64'd0);
  endtask

  initial begin
    logic found;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    deq_ready      = 1'b0;
    #3;
    check_reset_outputs("rst");

    // Reset release and steady streaming from RESET_PC.
    @(posedge clk); #1;
    rst = 1'b1;
    sb_restart(64'h0);
    check("boot_req", {63'd0, imem_req}, 64'd0);
    deq_ready = 1'b1;
    tick();
    check("first_req",  {63'd0, imem_req}, 64'd1);
    check("first_addr", imem_addr, 64'h0);
    tick();
`ifdef FETCH_QUEUE_BYPASS_EN
    check("bypass_valid", {63'd0, deq_valid}, 64'd1);
    check("bypass_occ",   64'(occupancy), 64'd0);
`else
    check("fifo_latency_valid", {63'd0, deq_valid}, 64'd0);
`endif
    tick();
    for (int i = 0; i < 8; i++) begin
      check("steady_valid", {63'd0, deq_valid}, 64'd1);
      tick();
    end

    // Back-pressure: queue fills, requests stop.
    deq_ready = 1'b0;
    repeat (10) tick();
    check("full_occ",   64'(occupancy), 64'(DEPTH));
    check("full_req",   {63'd0, imem_req}, 64'd0);
    check("full_valid", {63'd0, deq_valid}, 64'd1);

    // Pop one, let one request go in flight: occupancy 3 + inflight.
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    tick();
    check("pre_redir_occ", 64'(occupancy), 64'd3);
    check("pre_redir_req", {63'd0, imem_req}, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    tick();
    redirect_valid = 1'b0;
    sb_restart(64'h100);
    check("kill_occ",   64'(occupancy), 64'd0);
    check("kill_req",   {63'd0, imem_req}, 64'd0);
    check("kill_valid", {63'd0, deq_valid}, 64'd0);
    tick();
    check("target_req",  {63'd0, imem_req}, 64'd1);
    check("target_addr", imem_addr, 64'h100);
    deq_ready = 1'b1;
    repeat (6) tick();

    // Redirect coinciding with the handshake of PC 0x20.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h10;
    tick();
    redirect_valid = 1'b0;
    sb_restart(64'h10);
    n_0x20 = 0;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (deq_valid === 1'b1 && deq_pc === 64'h20) found = 1'b1;
      else tick();
    end
    check("reach_0x20", {63'd0, found}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    redirect_valid = 1'b0;
    sb_restart(64'h200);
    check("kill2_valid", {63'd0, deq_valid}, 64'd0);
    tick();
    check("req2_valid", {63'd0, deq_valid}, 64'd0);
    check("req2_addr",  imem_addr, 64'h200);
    repeat (8) tick();
    check("once_0x20", 64'(n_0x20), 64'd1);

    // Asynchronous reset in mid-cycle while streaming.
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    tick();
    rst = 1'b1;
    sb_restart(64'h0);
    check("reboot_req", {63'd0, imem_req}, 64'd0);
    tick();
    check("refetch_req",  {63'd0, imem_req}, 64'd1);
    check("refetch_addr", imem_addr, 64'h0);
    repeat (10) tick();

    deq_ready = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
